// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded modulo-N digit counters: direction type,
// digit width helper and the largest supported radix.
package counter_pkg;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam int MAX_RADIX = 16;

    function automatic int digit_width(input int radix);
        return (radix < 2) ? 1 : $clog2(radix);
    endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One counter digit cycling 0..RADIX-1 with load, step and direction control.
// Out-of-range load values and stray out-of-range states both collapse to 0.
module mod_n_digit
    import counter_pkg::*;
#(
    parameter  int RADIX = 10,
    localparam int DW    = digit_width(RADIX)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    input  logic          step,
    input  dir_t          dir,
    output logic [DW-1:0] value,
    output logic          at_max,
    output logic          at_zero,
    output logic          range_err
);

    // One extra bit keeps RADIX=16 representable when range-checking a 4-bit digit.
    localparam logic [DW:0]   RADIX_W = (DW+1)'(RADIX);
    localparam logic [DW-1:0] MAX_D   = DW'(RADIX - 1);
    localparam logic [DW-1:0] ZERO_D  = {DW{1'b0}};

    logic [DW-1:0] r_value;
    logic [DW-1:0] w_next;

    assign value     = r_value;
    assign at_max    = (r_value == MAX_D);
    assign at_zero   = (r_value == ZERO_D);
    assign range_err = ({1'b0, load_digit} >= RADIX_W);

    // Value this digit takes when it steps in the current direction.
    always_comb begin
        w_next = r_value;
        if ({1'b0, r_value} >= RADIX_W) begin
            w_next = ZERO_D;
        end else if (dir == DOWN) begin
            w_next = at_zero ? MAX_D : (r_value - DW'(1));
        end else begin
            w_next = at_max ? ZERO_D : (r_value + DW'(1));
        end
    end

    // Digit register: reset, then load, then step, else hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_value <= ZERO_D;
        end else if (load) begin
            r_value <= range_err ? ZERO_D : load_digit;
        end else if (step) begin
            r_value <= w_next;
        end else begin
            r_value <= r_value;
        end
    end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Multi-digit up/down modulo-N counter with parallel load, terminal count and
// load range error. Define COUNTER_SATURATE_EN to hold at the terminal value.
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter  int RADIX  = 10,
    parameter  int DIGITS = 2,
    localparam int DW     = digit_width(RADIX)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 reverse,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_value,
    output logic [DIGITS*DW-1:0] count,
    output logic                 tc,
    output logic                 load_err
);

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_zero;
    logic [DIGITS-1:0] w_range_err;
    logic [DIGITS-1:0] w_step;
    dir_t              w_dir;
    logic              w_terminal;
    logic              w_hold;
    logic              r_load_err;

    assign w_dir      = reverse ? DOWN : UP;
    assign w_terminal = (w_dir == DOWN) ? (&w_at_zero) : (&w_at_max);
    assign tc         = enable & w_terminal;
    assign load_err   = r_load_err;

`ifdef COUNTER_SATURATE_EN
    assign w_hold = w_terminal;
`else
    assign w_hold = 1'b0;
`endif

    // Ripple the step through the digits: a digit moves only when every lower
    // digit is at its rollover value for the current direction.
    always_comb begin
        logic w_carry;
        w_carry = enable & ~load & ~w_hold;
        for (int i = 0; i < DIGITS; i++) begin
            w_step[i] = w_carry;
            w_carry   = w_carry & ((w_dir == DOWN) ? w_at_zero[i] : w_at_max[i]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        mod_n_digit #(
            .RADIX(RADIX)
        ) u_digit (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (load),
            .load_digit(load_value[g*DW +: DW]),
            .step      (w_step[g]),
            .dir       (w_dir),
            .value     (count[g*DW +: DW]),
            .at_max    (w_at_max[g]),
            .at_zero   (w_at_zero[g]),
            .range_err (w_range_err[g])
        );
    end

    // Pulse load_err for the cycle after a load that carried a bad digit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load & (|w_range_err);
        end
    end

endmodule

// File: doc/mod_n_updown_counter.md
# mod_n_updown_counter

Parametrised synchronous up/down modulo-N counter built from cascaded digits, each counting 0..RADIX-1. It is the multi-digit successor to the single-decade up/down counter. It adds:
- configurable radix and digit count
- parallel load with range checking
- a terminal-count output for cascading further counters
- optional saturation

It sits in the display/timebase path, driving digit decoders, and chains with other instances through `tc`.

## Interface
Parameters:
- `RADIX`, default 10: modulus of each digit, 2..16.
- `DIGITS`, default 2: number of cascaded digits, 1..8.
- `DW`, derived as $clog2(RADIX): bits per digit. Not overridable.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset_n`, input, 1: synchronous, active-low reset. Sampled on `clk` rising edge.
- `enable`, input, 1: count one step this cycle.
- `reverse`, input, 1: direction select; 0 = up, 1 = down.
- `load`, input, 1: parallel load of `load_value`.
- `load_value`, input, DIGITS*DW: digit i occupies bits [i*DW +: DW]; digit 0 is least significant.
- `count`, output, DIGITS*DW: current value, same packing as `load_value`.
- `tc`, output, 1: terminal count (combinational). Asserted when `enable`=1 and the counter sits at its terminal value for the current direction.
  - Up: all digits = RADIX-1.
  - Down: all digits = 0.
- `load_err`, output, 1: registered one-cycle pulse. Set when a load contained an out-of-range digit.

## Operation
- Priority on each rising edge: `reset_n`=0, then `load`, then `enable`, then hold.
- Reset: `count` = 0 and `load_err` = 0.
- Load: each digit takes its `load_value` field.
  - Any field >= RADIX is written as 0 instead.
  - `load_err` = 1 for the next cycle if any field was out of range, otherwise 0.
  - `enable` is ignored in a load cycle.
- Count up: digit 0 always steps. Digit i steps only when digits 0..i-1 are all RADIX-1.
  - A stepping digit at RADIX-1 goes to 0; otherwise it increments.
- Count down: digit i steps only when digits 0..i-1 are all 0.
  - A stepping digit at 0 goes to RADIX-1; otherwise it decrements.
- Wrap-around: all digits RADIX-1 counting up gives all digits 0. All digits 0 counting down gives all digits RADIX-1.
- `load_err` is 0 in every cycle not following an erroneous load.
- A direction change takes effect on the same edge with no extra cycle. `tc` follows `reverse` combinationally.
- If the count state ever holds a digit >= RADIX (non-power-of-two radix), the next enabled step forces that digit to 0.

## Timing
- Latency: `count` reflects load, enable or reset on the edge where the input is sampled (1 cycle).
- `tc` has zero latency from `enable`, `reverse` and `count`. It is valid in the same cycle as the edge that performs the wrap.
- Cascading: the next instance's `enable` is driven by this instance's `tc`. Both wrap on the same edge.
- Reset mid-count or during a load cycle: reset wins; `count` = 0 and `load_err` = 0 on that edge.
- `load` and `enable` in the same cycle: the load wins and no step occurs. `tc` may still assert combinationally; downstream stages must qualify it themselves if needed.

## Configuration
- `COUNTER_SATURATE_EN` defined:
  - Counting up at all-max holds the value; counting down at all-zero holds the value.
  - `tc` still asserts while held.
- `COUNTER_SATURATE_EN` undefined: wrap-around as described above (default).

## Structure
- Shared package `counter_pkg` holds:
  - the function `digit_width(radix)`
  - the typedef `dir_t` (UP = 0, DOWN = 1)
  - the constant `MAX_RADIX` = 16
- Sub-module `mod_n_digit`, one per digit, generated DIGITS times.
  - Inputs: clk, reset_n, load, load_digit, step, dir.
  - Outputs: value, at_max, at_zero, range_err.
  - Top level computes each digit's step from the lower digits' at_max/at_zero chain.

## Test plan
- Reset, then enable=1, reverse=0 for 100 cycles (RADIX=10, DIGITS=2): count sequence 00..99 then 00; tc high only in the cycle at 99.
- Load 0x42, then reverse=1 and enable for 43 cycles: 42, 41, ..., 00, 99; tc high only at 00.
- Load with digit 0 = 0xC and digit 1 = 0x3: count = 0x30; load_err = 1 for exactly one cycle, then 0.
- load=1 and enable=1 together with load_value=0x55: count = 55 and no step occurs. Then reset_n=0 mid-count at 57: count = 00 on that edge.
- Toggle reverse every cycle from 50 with enable=1: 51, 50, 51, 50, and so on; no lost or extra steps.
- With `COUNTER_SATURATE_EN`: count up at 99 holds 99 with tc=1; count down at 00 holds 00 with tc=1.
